sdram_local_arbiter: RTL and testbench
======================================

Name: sdram_local_arbiter

Overview:
- Two-client arbiter and sequencer in front of the DDR2 controller local interface.
- Round-robin between client 0 and client 1; issues one burst request at a time.
- Handles write-data beat handshaking against local_ready.
- Tracks outstanding reads in a tag FIFO so local_rdata_valid beats are routed to the client that issued the read.

Parameters:
ADDR_W, 24, local address width
DATA_W, 16, local data width
BE_W, 2, byte-enable width
MAX_BURST, 4, largest legal burst size in beats (fits the 3-bit size field)
TAG_DEPTH, 8, max outstanding read bursts (power of 2)

Ports:
phy_clk  in  1  sole clock
reset_phy_clk_n  in  1  asynchronous active-low reset
status_init_done  in  1  controller init complete; no grants while 0
c0_req  in  1  request, held until c0_gnt
c0_wr  in  1  1=write, 0=read
c0_addr  in  ADDR_W  burst start address
c0_size  in  3  burst beats
c0_be  in  BE_W  byte enables for current write beat
c0_wdata  in  DATA_W  current write beat
c0_gnt  out  1  one-cycle pulse, request latched
c0_wdata_ack  out  1  current write beat consumed; present next beat
c0_rdata  out  DATA_W  read data (local_rdata fan-out)
c0_rdata_valid  out  1  read beat for client 0
c1_*  (same set, same widths/directions)  client 1
local_ready  in  1  controller accepts request this cycle
local_write_req / local_read_req  out  1  request strobes
local_address  out  ADDR_W  latched burst address
local_size  out  3  latched burst size
local_burstbegin  out  1  first beat of burst
local_be  out  BE_W  owner's c*_be
local_wdata  out  DATA_W  owner's c*_wdata
local_rdata  in  DATA_W  read data
local_rdata_valid  in  1  read beat valid
err_rdata  out  1  sticky: rdata_valid with empty tag FIFO

Behaviour:
- Reset (async, any state):
  - FSM=IDLE; all strobes, gnt, ack, rdata_valid and err_rdata = 0.
  - local_address/size = 0; tag FIFO emptied; beat counters = 0.
  - RR pointer = "last owner 1", so client 0 wins the first tie.
  - In-flight reads are discarded.
- Size rule: latched size = 1 if c*_size==0; MAX_BURST if c*_size>MAX_BURST; else c*_size.
- FSM states: IDLE, WR_BURST, RD_ISSUE.
- IDLE:
  - Eligible client = req=1 AND status_init_done=1 AND (wr=1 OR tag count<TAG_DEPTH).
  - One eligible: it wins. Both eligible: the non-last-owner wins.
  - On win: pulse c*_gnt; latch owner, addr, size, wr; update RR pointer.
  - Next state: WR_BURST if wr=1, else RD_ISSUE.
  - Latency: req sampled in cycle N -> gnt in N, local_*_req asserted in N+1 (registered).
- WR_BURST:
  - local_write_req=1; local_address/local_size held; local_burstbegin=1 until the first beat is accepted.
  - local_wdata/local_be = owner's inputs (combinational mux).
  - Beat accepted when local_ready=1: owner's wdata_ack=1 that cycle, beat counter +1.
  - local_ready=0: all outputs held stable, no ack.
  - After last beat accepted -> IDLE; strobe deasserts next cycle.
- RD_ISSUE:
  - local_read_req=1 and local_burstbegin=1, held until local_ready=1.
  - On accept: push {owner, size} into tag FIFO -> IDLE.
  - The full check at grant is sufficient: only one read can be pending issue.
- Back-to-back: IDLE costs one cycle between bursts. Arbitration is never pre-empted mid-burst.
- Read return (independent of FSM):
  - Each local_rdata_valid routes to the tag FIFO head's client (c*_rdata_valid=1 same cycle, combinational) and increments the return counter.
  - On the beat equal to head size: pop head, counter=0.
  - Push and pop in the same cycle are allowed; count unchanged.
  - local_rdata_valid with the FIFO empty: no client valid, err_rdata set and sticky until reset.
- c0_rdata = c1_rdata = local_rdata always.
- status_init_done falling mid-burst: the current burst completes; no new grants.

Test Plan:
1. status_init_done=0, c0_req=1 for 10 cycles -> no gnt, no local req. Raise init_done -> c0_gnt the same cycle, local_write_req the next cycle.
2. c0 write addr 0x000100 size 4 data A0..A3, local_ready=1 -> 4 cycles write_req, burstbegin on beat 1 only, 4 wdata_ack pulses, local_wdata sequence A0..A3, address 0x000100 throughout.
3. Same write, local_ready=0 on beats 2 and 3 for 1 cycle each -> outputs stable while stalled, burst takes 6 cycles, still exactly 4 acks.
4. c0 and c1 both continuously requesting size-1 writes -> grants alternate c0,c1,c0,c1. c1_size=0 -> local_size=1; c1_size=7 -> local_size=4.
5. c0 read size 2 then c1 read size 3; controller returns 5 valid beats D0..D4 -> D0,D1 flagged to c0, D2..D4 to c1, tag FIFO empty after.
6. 8 reads issued with no return -> 9th read not granted while a c1 write is still granted. Return one full burst -> 9th read granted. Extra rdata_valid with FIFO empty -> err_rdata=1, held.

Source files
------------

// File: rtl/sdram_local_arbiter.sv
// sdram_local_arbiter: two-client round-robin arbiter/sequencer for the DDR2 local interface,
// with a tag FIFO that routes returning read beats back to the issuing client.
module sdram_local_arbiter #(
    parameter int ADDR_W    = 24,
    parameter int DATA_W    = 16,
    parameter int BE_W      = 2,
    parameter int MAX_BURST = 4,
    parameter int TAG_DEPTH = 8
) (
    input  logic              phy_clk,
    input  logic              reset_phy_clk_n,
    input  logic              status_init_done,
    input  logic              c0_req,
    input  logic              c0_wr,
    input  logic [ADDR_W-1:0] c0_addr,
    input  logic [2:0]        c0_size,
    input  logic [BE_W-1:0]   c0_be,
    input  logic [DATA_W-1:0] c0_wdata,
    output logic              c0_gnt,
    output logic              c0_wdata_ack,
    output logic [DATA_W-1:0] c0_rdata,
    output logic              c0_rdata_valid,
    input  logic              c1_req,
    input  logic              c1_wr,
    input  logic [ADDR_W-1:0] c1_addr,
    input  logic [2:0]        c1_size,
    input  logic [BE_W-1:0]   c1_be,
    input  logic [DATA_W-1:0] c1_wdata,
    output logic              c1_gnt,
    output logic              c1_wdata_ack,
    output logic [DATA_W-1:0] c1_rdata,
    output logic              c1_rdata_valid,
    input  logic              local_ready,
    output logic              local_write_req,
    output logic              local_read_req,
    output logic [ADDR_W-1:0] local_address,
    output logic [2:0]        local_size,
    output logic              local_burstbegin,
    output logic [BE_W-1:0]   local_be,
    output logic [DATA_W-1:0] local_wdata,
    input  logic [DATA_W-1:0] local_rdata,
    input  logic              local_rdata_valid,
    output logic              err_rdata
);
    localparam int PW = $clog2(TAG_DEPTH);

    typedef enum logic [1:0] {IDLE, WR_BURST, RD_ISSUE} state_e;

    state_e            state_q, state_d;
    logic              owner_q, owner_d, last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        size_q, size_d, beat_q, beat_d;
    logic [3:0]        tag_q [TAG_DEPTH];
    logic [PW-1:0]     wptr_q, rptr_q;
    logic [PW:0]       cnt_q;
    logic [2:0]        ret_q;
    logic              err_q;
    logic              room, elig0, elig1, pick1, win;
    logic              push, pop, fifo_empty, rvalid, head_owner;
    logic [2:0]        head_size;

    function automatic logic [2:0] clamp_size(input logic [2:0] s);
        return (s == 3'd0) ? 3'd1 : (s > 3'(MAX_BURST)) ? 3'(MAX_BURST) : s;
    endfunction

    // Writes never consume a tag, so only reads are held back by a full FIFO.
    assign room  = cnt_q < (PW+1)'(TAG_DEPTH);
    assign elig0 = c0_req & status_init_done & (c0_wr | room);
    assign elig1 = c1_req & status_init_done & (c1_wr | room);
    assign pick1 = elig1 & (~elig0 | ~last_q);
    assign win   = (state_q == IDLE) & (elig0 | elig1);
    assign c0_gnt = win & ~pick1;
    assign c1_gnt = win & pick1;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        addr_d  = addr_q;
        size_d  = size_q;
        beat_d  = beat_q;
        case (state_q)
            IDLE: if (win) begin
                owner_d = pick1;
                last_d  = pick1;
                addr_d  = pick1 ? c1_addr : c0_addr;
                size_d  = clamp_size(pick1 ? c1_size : c0_size);
                state_d = (pick1 ? c1_wr : c0_wr) ? WR_BURST : RD_ISSUE;
            end
            WR_BURST: if (local_ready) begin
                beat_d  = (beat_q + 3'd1 == size_q) ? 3'd0 : beat_q + 3'd1;
                state_d = (beat_q + 3'd1 == size_q) ? IDLE : WR_BURST;
            end
            RD_ISSUE: if (local_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge phy_clk or negedge reset_phy_clk_n) begin
        if (!reset_phy_clk_n) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            addr_q  <= '0;
            size_q  <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            beat_q  <= beat_d;
        end
    end

    assign local_write_req  = state_q == WR_BURST;
    assign local_read_req   = state_q == RD_ISSUE;
    assign local_burstbegin = local_read_req | (local_write_req & (beat_q == 3'd0));
    assign local_address    = addr_q;
    assign local_size       = size_q;
    assign local_be         = owner_q ? c1_be : c0_be;
    assign local_wdata      = owner_q ? c1_wdata : c0_wdata;
    assign c0_wdata_ack     = local_write_req & local_ready & ~owner_q;
    assign c1_wdata_ack     = local_write_req & local_ready & owner_q;

    // Read-return path runs independently of the request FSM.
    assign push       = local_read_req & local_ready;
    assign {head_owner, head_size} = tag_q[rptr_q];
    assign fifo_empty = cnt_q == '0;
    assign rvalid     = local_rdata_valid & ~fifo_empty;
    assign pop        = rvalid & (ret_q + 3'd1 == head_size);
    assign c0_rdata   = local_rdata;
    assign c1_rdata   = local_rdata;
    assign c0_rdata_valid = rvalid & ~head_owner;
    assign c1_rdata_valid = rvalid & head_owner;
    assign err_rdata  = err_q;

    always_ff @(posedge phy_clk) begin
        if (push) tag_q[wptr_q] <= {owner_q, size_q};
    end

    always_ff @(posedge phy_clk or negedge reset_phy_clk_n) begin
        if (!reset_phy_clk_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            ret_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_q + PW'(push);
            rptr_q <= rptr_q + PW'(pop);
            cnt_q  <= cnt_q + (PW+1)'(push) - (PW+1)'(pop);
            ret_q  <= pop ? 3'd0 : rvalid ? ret_q + 3'd1 : ret_q;
            err_q  <= err_q | (local_rdata_valid & fifo_empty);
        end
    end
endmodule

// File: tb/tb_sdram_local_arbiter.sv
// tb_sdram_local_arbiter: randomized bench for sdram_local_arbiter checked against a
// transaction-level model (grant order, burst sizes, outstanding-read queue).
module tb_sdram_local_arbiter;
    logic        phy_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init = 1'b0;
    logic [1:0]  req = '0, wr = '0;
    logic [23:0] addr [2];
    logic [2:0]  size [2];
    logic [1:0]  be [2];
    logic [15:0] wd [2];
    logic        local_ready = 1'b0, rvld_in = 1'b0;
    logic [15:0] rdata_in = '0;
    logic        c0_gnt, c1_gnt, c0_ack, c1_ack, c0_rv, c1_rv;
    logic [15:0] c0_rd, c1_rd, lwd;
    logic        wreq, rreq, bb, err;
    logic [23:0] laddr;
    logic [2:0]  lsize;
    logic [1:0]  lbe, gnt, ack, rv;

    int n_chk = 0, n_err = 0;
    int last_own = 1, last_wait = 0, rcnt = 0;
    int q_c[$], q_n[$];
    bit exp_err = 1'b0;

    assign gnt = {c1_gnt, c0_gnt};
    assign ack = {c1_ack, c0_ack};
    assign rv  = {c1_rv, c0_rv};

    always #5 phy_clk = ~phy_clk;

    sdram_local_arbiter dut (
        .phy_clk(phy_clk), .reset_phy_clk_n(rst_n), .status_init_done(init),
        .c0_req(req[0]), .c0_wr(wr[0]), .c0_addr(addr[0]), .c0_size(size[0]), .c0_be(be[0]),
        .c0_wdata(wd[0]), .c0_gnt(c0_gnt), .c0_wdata_ack(c0_ack), .c0_rdata(c0_rd),
        .c0_rdata_valid(c0_rv),
        .c1_req(req[1]), .c1_wr(wr[1]), .c1_addr(addr[1]), .c1_size(size[1]), .c1_be(be[1]),
        .c1_wdata(wd[1]), .c1_gnt(c1_gnt), .c1_wdata_ack(c1_ack), .c1_rdata(c1_rd),
        .c1_rdata_valid(c1_rv),
        .local_ready(local_ready), .local_write_req(wreq), .local_read_req(rreq),
        .local_address(laddr), .local_size(lsize), .local_burstbegin(bb), .local_be(lbe),
        .local_wdata(lwd), .local_rdata(rdata_in), .local_rdata_valid(rvld_in), .err_rdata(err)
    );

    function automatic int clampf(input int s);
        return (s == 0) ? 1 : (s > 4) ? 4 : s;
    endfunction

    function automatic int total_out();
        int t = 0;
        foreach (q_n[i]) t += q_n[i];
        return t - rcnt;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge phy_clk);
        #1;
    endtask

    task automatic wait_gnt(input int c);
        last_wait = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge phy_clk);
            if (gnt[c]) begin
                last_wait = i;
                break;
            end
            step();
        end
        chk("gnt_seen", 32'(last_wait >= 0), 1);
        if (last_wait >= 0) begin
            chk("gnt_other", 32'(gnt[1-c]), 0);
            last_own = c;
        end
    endtask

    task automatic do_write(input int c, input logic [23:0] a, input int s, input int mask,
                            output int cyc);
        logic [15:0] d [4];
        logic [1:0]  b [4];
        int n = clampf(s), k = 0;
        for (int i = 0; i < 4; i++) begin
            d[i] = 16'($urandom);
            b[i] = 2'($urandom);
        end
        wr[c] = 1'b1; addr[c] = a; size[c] = 3'(s); wd[c] = d[0]; be[c] = b[0]; req[c] = 1'b1;
        wait_gnt(c);
        step();
        req[c] = 1'b0;
        cyc = 0;
        local_ready = !mask[0];
        while (k < n && cyc < 40) begin
            @(negedge phy_clk);
            chk("wr_req", 32'(wreq), 1);
            chk("wr_addr", 32'(laddr), 32'(a));
            chk("wr_size", 32'(lsize), n);
            chk("wr_bb", 32'(bb), 32'(k == 0));
            chk("wr_data", 32'(lwd), 32'(d[k]));
            chk("wr_be", 32'(lbe), 32'(b[k]));
            chk("wr_ack", 32'(ack[c]), 32'(local_ready));
            chk("wr_ack_other", 32'(ack[1-c]), 0);
            if (local_ready) k++;
            cyc++;
            step();
            if (k < n) begin
                wd[c] = d[k];
                be[c] = b[k];
            end
            local_ready = (cyc >= 32) ? 1'b1 : !mask[cyc];
        end
        chk("wr_beats", k, n);
        local_ready = 1'b0;
        @(negedge phy_clk);
        chk("wr_req_end", 32'(wreq), 0);
        step();
    endtask

    task automatic do_read(input int c, input logic [23:0] a, input int s, input int mask);
        int n = clampf(s), cyc = 0;
        bit done = 1'b0;
        wr[c] = 1'b0; addr[c] = a; size[c] = 3'(s); req[c] = 1'b1;
        wait_gnt(c);
        step();
        req[c] = 1'b0;
        local_ready = !mask[0];
        while (!done && cyc < 40) begin
            @(negedge phy_clk);
            chk("rd_req", 32'(rreq), 1);
            chk("rd_bb", 32'(bb), 1);
            chk("rd_addr", 32'(laddr), 32'(a));
            chk("rd_size", 32'(lsize), n);
            done = local_ready;
            cyc++;
            step();
            local_ready = (cyc >= 32) ? 1'b1 : !mask[cyc];
        end
        chk("rd_issued", 32'(done), 1);
        if (done) begin
            q_c.push_back(c);
            q_n.push_back(n);
        end
        local_ready = 1'b0;
        @(negedge phy_clk);
        chk("rd_req_end", 32'(rreq), 0);
        step();
    endtask

    task automatic ret_beats(input int n);
        for (int i = 0; i < n; i++) begin
            rdata_in = 16'($urandom);
            rvld_in = 1'b1;
            @(negedge phy_clk);
            chk("rdata0", 32'(c0_rd), 32'(rdata_in));
            chk("rdata1", 32'(c1_rd), 32'(rdata_in));
            chk("err_now", 32'(err), 32'(exp_err));
            if (q_c.size() == 0) begin
                chk("rv_empty", 32'(rv), 0);
                exp_err = 1'b1;
            end else begin
                chk("rv_route", 32'(rv), (q_c[0] == 0) ? 1 : 2);
                rcnt++;
                if (rcnt == q_n[0]) begin
                    void'(q_c.pop_front());
                    void'(q_n.pop_front());
                    rcnt = 0;
                end
            end
            step();
        end
        rvld_in = 1'b0;
    endtask

    task automatic rr_test(input int s1);
        int exp_c = 1 - last_own, own = 0, grants = 0;
        req = 2'b11; wr = 2'b11; size[0] = 3'd1; size[1] = 3'(s1); local_ready = 1'b1;
        for (int i = 0; i < 80 && grants < 6; i++) begin
            @(negedge phy_clk);
            if (gnt != 2'b00) begin
                chk("rr_gnt", 32'(gnt), (exp_c == 0) ? 1 : 2);
                own = gnt[1] ? 1 : 0;
                last_own = own;
                exp_c = 1 - own;
                grants++;
            end
            if (wreq) chk("rr_size", 32'(lsize), clampf(int'(size[own])));
            step();
        end
        req = 2'b00;
        chk("rr_grants", grants, 6);
        repeat (6) step();
        local_ready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    initial begin
        int cyc;
        for (int i = 0; i < 2; i++) begin
            addr[i] = '0; size[i] = '0; be[i] = '0; wd[i] = '0;
        end
        repeat (2) step();
        @(negedge phy_clk);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_wreq", 32'(wreq), 0);
        chk("rst_rreq", 32'(rreq), 0);
        chk("rst_addr", 32'(laddr), 0);
        chk("rst_size", 32'(lsize), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_rv", 32'(rv), 0);
        step();
        rst_n = 1'b1;
        // init not done: requests must be ignored
        wr[0] = 1'b1; req[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge phy_clk);
            chk("noinit_gnt", 32'(gnt), 0);
            chk("noinit_req", 32'({wreq, rreq}), 0);
            step();
        end
        init = 1'b1;
        do_write(0, 24'h000100, 4, 0, cyc);
        chk("t1_gnt_latency", last_wait, 0);
        chk("t2_cycles", cyc, 4);
        do_write(0, 24'h000100, 4, 32'b01010, cyc);
        chk("t3_cycles", cyc, 6);
        rr_test(0);
        rr_test(7);
        do_read(0, 24'h000200, 2, 0);
        do_read(1, 24'h000300, 3, 0);
        ret_beats(5);
        chk("t5_empty", q_c.size(), 0);
        for (int t = 0; t < 30; t++) begin
            int c = int'($urandom_range(1, 0));
            int s = int'($urandom_range(7, 0));
            logic [23:0] a = 24'($urandom);
            int m = int'($urandom);
            if ($urandom_range(1, 0) == 1 && q_c.size() < 8) do_read(c, a, s, m);
            else do_write(c, a, s, m, cyc);
            if (total_out() > 0 && (q_c.size() >= 6 || $urandom_range(3, 0) == 0))
                ret_beats(int'($urandom_range(total_out(), 1)));
        end
        if (total_out() > 0) ret_beats(total_out());
        // fill the tag FIFO, then a read must wait while a write still gets through
        for (int i = 0; i < 8; i++) do_read(i % 2, 24'($urandom), int'($urandom_range(4, 1)), 0);
        wr[0] = 1'b0; size[0] = 3'd2; addr[0] = 24'h00abcd; req[0] = 1'b1;
        do_write(1, 24'h000400, 2, 0, cyc);
        for (int i = 0; i < 3; i++) begin
            @(negedge phy_clk);
            chk("full_block", 32'(c0_gnt), 0);
            step();
        end
        ret_beats(q_n[0]);
        do_read(0, 24'h00abcd, 2, 0);
        chk("t6_regrant", last_wait, 0);
        ret_beats(total_out());
        ret_beats(1);
        for (int i = 0; i < 3; i++) begin
            @(negedge phy_clk);
            chk("err_sticky", 32'(err), 1);
            step();
        end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
